mem_arbiter: RTL

- Two-requester controller for the 512-word main RAM.
- Requester 0 is instruction fetch; requester 1 is data load/store.
- Serializes requests with round-robin fairness and drives the RAM read/write strobes, address and write data.
- Captures the RAM's registered output and returns it to the winning requester with a one-cycle acknowledge; out-of-range addresses are rejected without touching the RAM.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin controller for the main RAM.
// Requester 0 is instruction fetch, requester 1 is data load/store.
// One access is in flight at a time. The winner's request is latched in IDLE,
// the RAM strobe is held for ACCESS_CYCLES cycles, and a one-cycle ack returns
// the captured read data. Out-of-range addresses skip the RAM and return an error.
module mem_arbiter #(
  parameter int DEPTH         = 512,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  // Latched request of the current winner
  logic             r_grant;
  logic             r_last_grant;
  logic             r_we;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic             w_win;
  logic             w_sel_we;
  logic [31:0]      w_sel_addr;
  logic [31:0]      w_sel_wdata;
  logic             w_in_range;
  logic             w_start;
  logic             w_start_ok;
  logic             w_cnt_done;

  logic             w_ack_fire;
  logic [31:0]      w_resp_data;
  logic             w_ram_read_nxt;
  logic             w_ram_write_nxt;
  logic [31:0]      w_ram_addr_nxt;
  logic [31:0]      w_ram_data_nxt;
  logic             w_busy_nxt;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  assign w_any       = m0_req | m1_req;
  assign w_win       = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_sel_we    = w_win ? m1_we    : m0_we;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;
  assign w_in_range  = (w_sel_addr < 32'(DEPTH));
  assign w_start     = (r_state == IDLE) && w_any;
  assign w_start_ok  = w_start && w_in_range;
  assign w_cnt_done  = (r_cnt == '0);

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!clear_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next_state = w_in_range ? ACCESS : RESP;
      ACCESS:  if (w_cnt_done) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ram_read_nxt  = 1'b0;
    w_ram_write_nxt = 1'b0;
    w_ram_addr_nxt  = '0;
    w_ram_data_nxt  = '0;
    // Normal accesses complete on the last strobe edge; errors complete one edge after entering RESP.
    w_ack_fire      = ((r_state == ACCESS) && w_cnt_done) || ((r_state == RESP) && r_err);
    w_resp_data     = (r_err || r_we) ? 32'd0 : ram_rdata;
    w_busy_nxt      = (w_next_state != IDLE);
    if (w_start_ok) begin
      w_ram_read_nxt  = ~w_sel_we;
      w_ram_write_nxt = w_sel_we;
      w_ram_addr_nxt  = w_sel_addr;
      w_ram_data_nxt  = w_sel_we ? w_sel_wdata : 32'd0;
    end else if ((r_state == ACCESS) && !w_cnt_done) begin
      w_ram_read_nxt  = ~r_we;
      w_ram_write_nxt = r_we;
      w_ram_addr_nxt  = r_addr;
      w_ram_data_nxt  = r_we ? r_wdata : 32'd0;
    end
  end

  // Request latch, access counter and output registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      ram_read     <= 1'b0;
      ram_write    <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      busy         <= 1'b0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
      m1_rdata     <= '0;
    end else begin
      ram_read  <= w_ram_read_nxt;
      ram_write <= w_ram_write_nxt;
      ram_addr  <= w_ram_addr_nxt;
      ram_data  <= w_ram_data_nxt;
      busy      <= w_busy_nxt;

      if (w_start) begin
        r_grant      <= w_win;
        r_last_grant <= w_win;
        r_we         <= w_sel_we;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_err        <= ~w_in_range;
        r_cnt        <= CNT_W'(ACCESS_CYCLES - 1);
      end else if ((r_state == ACCESS) && !w_cnt_done) begin
        r_cnt <= r_cnt - 1'b1;
      end

      m0_ack <= w_ack_fire & ~r_grant;
      m1_ack <= w_ack_fire & r_grant;
      // err and rdata only change with that requester's own ack
      if (w_ack_fire && !r_grant) begin
        m0_err   <= r_err;
        m0_rdata <= w_resp_data;
      end
      if (w_ack_fire && r_grant) begin
        m1_err   <= r_err;
        m1_rdata <= w_resp_data;
      end
    end
  end

endmodule
